foc_sequencer: RTL and testbench

FOC_SEQUENCER -- requirements
Module: foc_sequencer

---
 rtl/foc_sequencer.sv | 138 +++++++++++++
 tb/tb_foc_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/foc_sequencer.sv
// FOC control-cycle sequencer: captures a sample set, then starts each processing
// stage in turn, waiting on its done (or a fixed single cycle), with timeout and abort.
module foc_sequencer #(
  parameter int                  D_WIDTH    = 16,
  parameter int                  N_CH       = 6,
  parameter int                  N_STAGES   = 6,
  parameter logic [N_STAGES-1:0] FIXED_MASK = 6'b001000,
  parameter int                  TIMEOUT    = 1024,
  parameter int                  CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     valid,
  output logic                     ready,
  input  logic [N_CH*D_WIDTH-1:0]  sample_in,
  output logic [N_CH*D_WIDTH-1:0]  sample_r,
  output logic [N_STAGES-1:0]      stage_start,
  input  logic [N_STAGES-1:0]      stage_done,
  output logic                     sub_rstb,
  output logic                     cycle_done,
  input  logic                     abort,
  input  logic                     fault_clr,
  output logic                     fault,
  output logic [3:0]               fault_stage,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         overrun_cnt
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, START, WAIT, CLEAR, FAULT} state_t;

  state_t        state_r;
  logic [3:0]    idx_r;
  logic [TW-1:0] timer_r;
  logic          fixed_s;
  logic          done_s;
  logic          last_s;

  // Decode the current stage's fixed flag and done input without an out-of-range select.
  always_comb begin
    fixed_s = 1'b0;
    done_s  = 1'b0;
    for (int i = 0; i < N_STAGES; i++) begin
      fixed_s |= FIXED_MASK[i] & (idx_r == 4'(i));
      done_s  |= stage_done[i] & (idx_r == 4'(i));
    end
    last_s = (idx_r == 4'(N_STAGES - 1));
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_r     <= IDLE;
      idx_r       <= 4'd0;
      timer_r     <= '0;
      ready       <= 1'b1;
      sample_r    <= '0;
      stage_start <= '0;
      sub_rstb    <= 1'b1;
      cycle_done  <= 1'b0;
      fault       <= 1'b0;
      fault_stage <= 4'd0;
      cycle_cnt   <= '0;
      overrun_cnt <= '0;
    end else begin
      stage_start <= '0;
      cycle_done  <= 1'b0;
      if (valid && !ready && (overrun_cnt != '1)) begin
        overrun_cnt <= overrun_cnt + CNT_W'(1);
      end
      case (state_r)
        IDLE: begin
          if (valid) begin
            sample_r    <= sample_in;
            idx_r       <= 4'd0;
            ready       <= 1'b0;
            stage_start <= N_STAGES'(1);
            state_r     <= START;
          end
        end
        START: begin
          if (abort) begin
            sub_rstb <= 1'b0;
            state_r  <= CLEAR;
          end else begin
            timer_r <= '0;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          // Done on the final timer cycle still wins over the timeout.
          if (abort) begin
            sub_rstb <= 1'b0;
            state_r  <= CLEAR;
          end else if (fixed_s || done_s) begin
            if (last_s) begin
              sub_rstb   <= 1'b0;
              cycle_done <= 1'b1;
              cycle_cnt  <= cycle_cnt + CNT_W'(1);
              state_r    <= CLEAR;
            end else begin
              idx_r       <= idx_r + 4'd1;
              stage_start <= N_STAGES'(1) << (idx_r + 4'd1);
              state_r     <= START;
            end
          end else if (timer_r == TW'(TIMEOUT - 1)) begin
            fault       <= 1'b1;
            fault_stage <= idx_r;
            sub_rstb    <= 1'b0;
            state_r     <= FAULT;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        CLEAR: begin
          sub_rstb <= 1'b1;
          ready    <= 1'b1;
          state_r  <= IDLE;
        end
        FAULT: begin
          if (fault_clr) begin
            fault    <= 1'b0;
            sub_rstb <= 1'b1;
            ready    <= 1'b1;
            state_r  <= IDLE;
          end
        end
        default: begin
          sub_rstb <= 1'b1;
          ready    <= 1'b1;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_foc_sequencer.sv
// Directed bench for foc_sequencer: full cycle, overrun, timeout, last-cycle done, abort, reset.
module tb_foc_sequencer;

  localparam int DW = 16;
  localparam int NC = 6;
  localparam int NS = 6;
  localparam int CW = 8;

  logic             clk = 1'b0;
  logic             rstb = 1'b0;
  logic             valid = 1'b0;
  logic             ready;
  logic [NC*DW-1:0] sample_in = '0;
  logic [NC*DW-1:0] sample_r;
  logic [NS-1:0]    stage_start;
  logic [NS-1:0]    stage_done = '0;
  logic             sub_rstb;
  logic             cycle_done;
  logic             abort = 1'b0;
  logic             fault_clr = 1'b0;
  logic             fault;
  logic [3:0]       fault_stage;
  logic [CW-1:0]    cycle_cnt;
  logic [CW-1:0]    overrun_cnt;

  int checks = 0;
  int errors = 0;
  int pend_cnt = 0;
  int pend_idx = 0;
  bit resp_en = 1'b0;
  int sc[NS] = '{1, 5, 9, 13, 15, 19};
  logic [NS-1:0] exp_start;
  int done_pulses;

  foc_sequencer dut (
    .clk(clk), .rstb(rstb), .valid(valid), .ready(ready),
    .sample_in(sample_in), .sample_r(sample_r),
    .stage_start(stage_start), .stage_done(stage_done),
    .sub_rstb(sub_rstb), .cycle_done(cycle_done),
    .abort(abort), .fault_clr(fault_clr), .fault(fault), .fault_stage(fault_stage),
    .cycle_cnt(cycle_cnt), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; emulate stage modules returning done 3 cycles after start.
  task automatic tick();
    @(negedge clk);
    stage_done = '0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) stage_done[pend_idx] = 1'b1;
    end
    if (resp_en && (stage_start != '0)) begin
      for (int i = 0; i < NS; i++) if (stage_start[i]) pend_idx = i;
      pend_cnt = 3;
    end
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    pend_cnt = 0;
    tick();
    check("rst_ready", ready, 1'b1);
    check("rst_start", stage_start, '0);
    check("rst_sub_rstb", sub_rstb, 1'b1);
    check("rst_cycle_done", cycle_done, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_fault_stage", fault_stage, 4'd0);
    check("rst_sample_r", sample_r, '0);
    check("rst_cycle_cnt", cycle_cnt, '0);
    check("rst_overrun_cnt", overrun_cnt, '0);
    rstb = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Full cycle with default stage timing.
    resp_en = 1'b1;
    sample_in = {NC{16'h0F0F}};
    valid = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == 1) valid = 1'b0;
      exp_start = '0;
      for (int i = 0; i < NS; i++) if (sc[i] == c) exp_start[i] = 1'b1;
      check($sformatf("start_c%0d", c), stage_start, exp_start);
      check($sformatf("cdone_c%0d", c), cycle_done, (c == 23) ? 1'b1 : 1'b0);
    end
    check("full_ready", ready, 1'b1);
    check("full_cycle_cnt", cycle_cnt, 8'd1);
    check("full_sample_r", sample_r, {NC{16'h0F0F}});

    // Overrun while busy leaves the captured sample untouched.
    sample_in = {NC{16'hA5A5}};
    valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    sample_in = {NC{16'h1234}};
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("ovr_sample_hold", sample_r, {NC{16'hA5A5}});
    check("ovr_cnt1", overrun_cnt, 8'd1);
    valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    valid = 1'b0;
    for (int i = 0; i < 60 && !ready; i++) tick();
    check("ovr_ready_back", ready, 1'b1);
    check("ovr_cnt_sat", overrun_cnt, 8'hFF);
    check("ovr_last_capture", sample_r, {NC{16'h1234}});
    do_reset();

    // Stage 1 never completes: timeout after 1024 WAIT cycles.
    resp_en = 1'b0;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("to_start0", stage_start, 6'b000001);
    tick();
    stage_done[0] = 1'b1;
    tick();
    check("to_start1", stage_start, 6'b000010);
    for (int i = 0; i < 1024; i++) tick();
    check("to_no_fault_yet", fault, 1'b0);
    tick();
    check("to_fault", fault, 1'b1);
    check("to_fault_stage", fault_stage, 4'd1);
    check("to_sub_rstb", sub_rstb, 1'b0);
    check("to_ready", ready, 1'b0);
    abort = 1'b1;
    tick();
    tick();
    abort = 1'b0;
    check("to_fault_held", fault, 1'b1);
    check("to_sub_rstb_held", sub_rstb, 1'b0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("clr_ready", ready, 1'b1);
    check("clr_fault", fault, 1'b0);
    check("clr_sub_rstb", sub_rstb, 1'b1);
    check("clr_cycle_cnt", cycle_cnt, 8'd0);

    // Done arriving on the final timer cycle advances instead of faulting.
    valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    stage_done[0] = 1'b1;
    tick();
    check("late_start1", stage_start, 6'b000010);
    for (int i = 0; i < 1024; i++) tick();
    stage_done[1] = 1'b1;
    tick();
    check("late_no_fault", fault, 1'b0);
    check("late_start2", stage_start, 6'b000100);

    // Abort during stage 2 WAIT.
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_sub_rstb", sub_rstb, 1'b0);
    check("abort_no_cdone", cycle_done, 1'b0);
    check("abort_ready_low", ready, 1'b0);
    tick();
    check("abort_ready", ready, 1'b1);
    check("abort_sub_rstb_back", sub_rstb, 1'b1);
    check("abort_cycle_cnt", cycle_cnt, 8'd0);

    // Reset during stage 4 WAIT, then a clean cycle.
    resp_en = 1'b1;
    sample_in = {NC{16'h5A5A}};
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 2; i <= 16; i++) tick();
    check("mid_wait4", stage_start, 6'b000000);
    check("mid_ready", ready, 1'b0);
    do_reset();
    valid = 1'b1;
    done_pulses = 0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == 1) valid = 1'b0;
      if (cycle_done) done_pulses++;
    end
    check("post_rst_pulses", done_pulses, 1);
    check("post_rst_cycle_cnt", cycle_cnt, 8'd1);
    check("post_rst_ready", ready, 1'b1);
    check("post_rst_sample", sample_r, {NC{16'h5A5A}});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
